// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states, digit type and constants for the binary-to-BCD converter
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef logic [3:0] bcd_digit_t;
    localparam int MAX_DEC = 9999;
    localparam int NUM_DIG = 4;
    localparam int ACC_DIG = NUM_DIG + 1;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t d_i,
    output bcd_digit_t d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 binary to 4-digit BCD converter, one bit per cycle.
// Define BCD_SATURATE_EN to clamp inputs above 9999 to 9999 and raise overflow.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       unidad,
    output logic [3:0]       decena,
    output logic [3:0]       centena,
    output logic [3:0]       miles,
    output logic             overflow
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int ACC_W = 4 * ACC_DIG;
    localparam int OUT_W = 4 * NUM_DIG;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_adj, acc_sh;
    logic [BIN_W-1:0]   bin_sh;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   dig_q, dig_d, res;
    logic               ovf_q, ovf_d, res_ovf;

    for (genvar g = 0; g < ACC_DIG; g++) begin : g_add3
        bcd_add3 u_add3 (.d_i(acc_q[4*g +: 4]), .d_o(acc_adj[4*g +: 4]));
    end

    assign {acc_sh, bin_sh} = {acc_adj, bin_q} << 1;

    // a nonzero fifth digit means the input exceeded the four-digit range
`ifdef BCD_SATURATE_EN
    assign res_ovf = acc_sh[OUT_W +: 4] != 4'd0;
    assign res     = res_ovf ? {NUM_DIG{4'd9}} : acc_sh[OUT_W-1:0];
`else
    assign res_ovf = 1'b0;
    assign res     = acc_sh[OUT_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        if (state_q == SHIFT) begin
            acc_d = acc_sh;
            bin_d = bin_sh;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = DONE;
                dig_d   = res;
                ovf_d   = res_ovf;
            end
        end else if (start) begin
            state_d = SHIFT;
            bin_d   = bin_in;
            acc_d   = '0;
            cnt_d   = CNT_W'(BIN_W);
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = state_q == SHIFT;
    assign done     = state_q == DONE;
    assign overflow = ovf_q;
    assign {miles, centena, decena, unidad} = dig_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed and random checks of bin_to_bcd_seq against a decimal-arithmetic model
module tb_bin_to_bcd_seq;
    localparam int BIN_W = 14;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic             busy, done, overflow;
    logic [3:0]       unidad, decena, centena, miles;
    int               checks = 0;
    int               failures = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done),
        .unidad(unidad), .decena(decena), .centena(centena), .miles(miles),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_digits(input int v);
        int m;
`ifdef BCD_SATURATE_EN
        if (v > 9999) return 16'h9999;
`endif
        m = v % 10000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic model_ovf(input int v);
`ifdef BCD_SATURATE_EN
        return v > 9999;
`else
        return (v < 0);
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input int v);
        logic [15:0] d;
        d = {miles, centena, decena, unidad};
        chk({tag, "_digits"}, int'(d), int'(model_digits(v)));
        chk({tag, "_ovf"}, int'(overflow), int'(model_ovf(v)));
        chk({tag, "_range"}, int'(miles <= 9 && centena <= 9 && decena <= 9 && unidad <= 9), 1);
    endtask

    task automatic launch(input int v);
        start = 1'b1;
        bin_in = BIN_W'(v);
    endtask

    // advance from the launch negedge until done; poke re-requests 77 mid-conversion
    task automatic finish_conv(input string tag, input int v, input int poke);
        int k;
        int nbusy;
        nbusy = 0;
        @(negedge clk);
        start = 1'b0;
        bin_in = BIN_W'($urandom);
        for (k = 1; k <= 40; k++) begin
            if (done) break;
            if (busy) nbusy++;
            start = (k == poke);
            bin_in = (k == poke) ? BIN_W'(77) : BIN_W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_latency"}, k, BIN_W + 1);
        chk({tag, "_busy_cycles"}, nbusy, BIN_W);
        chk({tag, "_busy_in_done"}, int'(busy), 0);
        chk_result(tag, v);
    endtask

    initial begin
        int v;
        int ndone;
        logic [15:0] held;
        start = 1'b1;
        bin_in = BIN_W'(1234);
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_digits", int'({miles, centena, decena, unidad}), 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);

        launch(1234);
        finish_conv("t1", 1234, 0);
        @(negedge clk);
        chk("t1_done_one_cycle", int'(done), 0);
        chk("t1_idle_after", int'(busy), 0);
        held = {miles, centena, decena, unidad};
        repeat (3) begin
            bin_in = BIN_W'($urandom);
            @(negedge clk);
        end
        chk("t1_hold", int'({miles, centena, decena, unidad}), int'(held));

        launch(0);
        finish_conv("t2_zero", 0, 0);
        @(negedge clk);
        launch(9999);
        finish_conv("t2_max", 9999, 0);
        @(negedge clk);
        launch(12345);
        finish_conv("t3", 12345, 0);
        @(negedge clk);

        launch(42);
        finish_conv("t4", 42, 5);

        @(negedge clk);
        launch(100);
        finish_conv("t5_prior", 100, 0);
        launch(5678);
        finish_conv("t5", 5678, 0);

        @(negedge clk);
        launch(8888);
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_ovf", int'(overflow), 0);
        chk("t6_digits", int'({miles, centena, decena, unidad}), 0);
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t6_no_done", ndone, 0);

        repeat (20) begin
            v = int'($urandom_range(0, (1 << BIN_W) - 1));
            @(negedge clk);
            launch(v);
            finish_conv("rand", v, 0);
        end

        @(negedge clk);
        launch(10000);
        finish_conv("b_10000", 10000, 0);
        @(negedge clk);
        launch((1 << BIN_W) - 1);
        finish_conv("b_allones", (1 << BIN_W) - 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
